gray_stream_decoder: RTL and testbench
======================================

# gray_stream_decoder

Receive side of a Gray-coded counter link: accepts a stream of Gray-coded samples over a valid/ready handshake, decodes each to binary, checks that consecutive samples differ by exactly one Gray step, and presents the binary value with step direction and error sideband through a registered output stage. It sits after a Gray counter or pointer source and feeds binary consumers such as occupancy logic and position trackers.

## Interface
- WIDTH, 5: code width in bits, ≥2.
- ERR_W, 8: error-counter width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- gray_vld  in  1  input sample valid.
- gray_in  in  WIDTH  Gray-coded sample.
- gray_rdy  out  1  decoder can accept a sample.
- bin_vld  out  1  output valid.
- bin_out  out  WIDTH  decoded binary value.
- step_up  out  1  sample is previous+1 (mod 2^WIDTH); valid with bin_vld.
- step_err  out  1  sample is not a single step from the previous one; valid with bin_vld.
- bin_rdy  in  1  downstream accepts output.
- err_clr  in  1  clear error counter (only with ERR_CNT_EN).
- err_cnt  out  ERR_W  saturating count of step errors (only with ERR_CNT_EN).

## Operation
- Input accepted when gray_vld && gray_rdy; gray_rdy = !bin_vld || bin_rdy (single output register, no bubble).
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i].
- FSM, two states:
  - FIRST (reset state): first accepted sample is loaded as reference; step_up=0, step_err=0; go to TRACK.
  - TRACK: compare new binary n to stored previous p. n == p+1 mod 2^WIDTH → step_up=1, step_err=0. n == p−1 mod 2^WIDTH → step_up=0, step_err=0. Anything else, including n == p (repeat) → step_err=1, step_up=0. p updates to n on every accept, error or not (resynchronise on the new value).
- Wrap-around is a legal step: p=2^WIDTH−1 → n=0 is up; p=0 → n=2^WIDTH−1 is down.
- Output register holds bin_out/step_up/step_err stable while bin_vld && !bin_rdy.
- Reset mid-stream: any held output is dropped, FSM returns to FIRST; next sample is never flagged.

## Timing
- Latency 1 cycle: sample accepted at edge k appears on bin_vld/bin_out after edge k; back-to-back throughput 1 sample/cycle when bin_rdy=1.
- Simultaneous accept and output handshake in one cycle: output register reloads, no stall.
- Reset values: gray_rdy=1 (after reset, combinational from bin_vld=0), bin_vld=0, bin_out=0, step_up=0, step_err=0, err_cnt=0; stored previous=0.
- err_cnt increments on the edge a sample with step_err is accepted into the output register; saturates at 2^ERR_W−1; err_clr takes priority over a simultaneous increment (result 0).

## Configuration
- GRAY_STREAM_DECODER_ERR_CNT_EN defined: err_clr and err_cnt present, counter behaves as above.
- Not defined: err_clr and err_cnt ports absent, no counter logic; step_err sideband unaffected.

## Structure
- Shared package gray_pkg: gray-to-binary and binary-to-Gray functions, default width constant, FSM state typedef (FIRST, TRACK).
- One sub-module is natural: gray_to_bin instance (WIDTH-parameterised, combinational) for the decode; step compare, FSM, output register and counter in the top.

## Test plan
- Reset, then gray_in=4 (bin 7), then 12 (bin 8) with bin_rdy=1 → bin_out 7 (step_err=0, step_up=0), then 8 with step_up=1, step_err=0.
- Full up sweep 0→31→0 in Gray, back-to-back → 33 outputs, step_up=1 on all but first, zero errors, including wrap 31→0.
- Down step: bin 8 then Gray 4 (bin 7) → step_up=0, step_err=0; then Gray 4 repeated → step_err=1; then Gray 7 (bin 5) → step_err=1, err_cnt=2.
- Backpressure: bin_rdy=0 for 3 cycles with gray_vld held → gray_rdy=0 after first accept, bin_out stable, no sample lost or duplicated on release.
- Reset asserted with bin_vld=1 and FSM in TRACK → bin_vld=0 next cycle; next sample, e.g. Gray 20 (bin 24), accepted with step_err=0.
- With ERR_CNT_EN, ERR_W=2: 4 consecutive error samples → err_cnt saturates at 3; err_clr concurrent with error → err_cnt=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code stream receive path.
// Contents: default code width, FSM state encoding (FIRST, TRACK),
// gray2bin / bin2gray helpers on a CODE_MAX_W-bit container.
// Callers narrower than CODE_MAX_W zero-extend their input and truncate
// the result. This is exact because zero upper Gray bits decode to zero
// upper binary bits.
package gray_pkg;

   localparam int unsigned GRAY_W_DEFAULT = 5;
   localparam int unsigned CODE_MAX_W     = 32;

   typedef logic [0:0] state_t;
   localparam state_t FIRST = 1'b0;
   localparam state_t TRACK = 1'b1;

   // Prefix XOR from the MSB down.
   function automatic logic [CODE_MAX_W-1:0] gray2bin(input logic [CODE_MAX_W-1:0] g);
      logic [CODE_MAX_W-1:0] b;
      b[CODE_MAX_W-1] = g[CODE_MAX_W-1];
      for (int i = CODE_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [CODE_MAX_W-1:0] bin2gray(input logic [CODE_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray_stream_decoder_gray_to_bin.sv
// Combinational Gray-to-binary converter.
// Ports: gray (WIDTH-bit Gray code in), bin (WIDTH-bit binary out).
// WIDTH must not exceed gray_pkg::CODE_MAX_W.
module gray_to_bin
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   always_comb begin
      bin = WIDTH'(gray2bin(CODE_MAX_W'(gray)));
   end

endmodule

// File: rtl/gray_stream_decoder.sv
// Gray-coded counter link receiver.
// Accepts Gray samples on a valid/ready handshake and decodes each one to
// binary. It checks that each sample is a single step (up or down, with
// wrap) from the previous sample, and presents the binary value with the
// step_up and step_err sideband from one output register.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   gray_vld/gray_in   input sample handshake and data
//   gray_rdy           high when the output register is empty or draining
//   bin_rdy            downstream accept
//   bin_vld/bin_out    output valid and decoded binary value
//   step_up/step_err   step classification, qualified by bin_vld
//   err_clr/err_cnt    saturating step-error counter and clear
//                      (present only with GRAY_STREAM_DECODER_ERR_CNT_EN)
// Optional feature macro: GRAY_STREAM_DECODER_ERR_CNT_EN
module gray_stream_decoder
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = GRAY_W_DEFAULT,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gray_vld,
   input  logic [WIDTH-1:0] gray_in,
   output logic             gray_rdy,
   input  logic             bin_rdy,
`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
   input  logic             err_clr,
   output logic [ERR_W-1:0] err_cnt,
`endif
   output logic             bin_vld,
   output logic [WIDTH-1:0] bin_out,
   output logic             step_up,
   output logic             step_err
);

   // Reject unusable parameter values at elaboration.
   if (WIDTH < 2 || WIDTH > CODE_MAX_W || ERR_W < 1) begin : g_param_check
      $error("gray_stream_decoder: unsupported WIDTH/ERR_W");
   end

   logic             accept;
   logic [WIDTH-1:0] bin_c;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_inc;
   logic [WIDTH-1:0] prev_dec;
   state_t           state_q;
   state_t           state_d;
   logic             step_up_d;
   logic             step_err_d;

   // A single output register can accept a new sample while it drains.
   always_comb begin
      gray_rdy = !bin_vld || bin_rdy;
      accept   = gray_vld && gray_rdy;
   end

   gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
      .gray (gray_in),
      .bin  (bin_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FIRST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and step classification. The increment and decrement wrap
   // modulo 2^WIDTH by truncation.
   always_comb begin
      state_d    = state_q;
      step_up_d  = 1'b0;
      step_err_d = 1'b0;
      prev_inc   = prev_q + WIDTH'(1);
      prev_dec   = prev_q - WIDTH'(1);
      case (state_q)
         FIRST: begin
            if (accept) begin
               state_d = TRACK;
            end
         end
         TRACK: begin
            if (accept) begin
               if (bin_c == prev_inc) begin
                  step_up_d = 1'b1;
               end else if (bin_c != prev_dec) begin
                  step_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = FIRST;
         end
      endcase
   end

   // The reference always follows the latest accepted sample. An error
   // therefore resynchronises on the new value.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
      end else if (accept) begin
         prev_q <= bin_c;
      end
   end

   // Output register. It holds its value while stalled and reloads in the
   // same cycle that the downstream side drains it.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_vld  <= 1'b0;
         bin_out  <= '0;
         step_up  <= 1'b0;
         step_err <= 1'b0;
      end else if (accept) begin
         bin_vld  <= 1'b1;
         bin_out  <= bin_c;
         step_up  <= step_up_d;
         step_err <= step_err_d;
      end else if (bin_rdy) begin
         bin_vld  <= 1'b0;
      end
   end

`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
   // Saturating error counter. A clear wins over a simultaneous increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (accept && step_err_d && (err_cnt != {ERR_W{1'b1}})) begin
         err_cnt <= err_cnt + ERR_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Self-checking bench for gray_stream_decoder: directed steps followed by
// random traffic, all compared against a transaction-level reference model.
module tb_gray_stream_decoder;

   localparam int unsigned W     = 5;
   localparam int unsigned ERR_W = 2;
   localparam int unsigned MOD   = 1 << W;

   logic             clk = 1'b0;
   logic             rst;
   logic             gray_vld;
   logic [W-1:0]     gray_in;
   logic             gray_rdy;
   logic             bin_rdy;
   logic             bin_vld;
   logic [W-1:0]     bin_out;
   logic             step_up;
   logic             step_err;
`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
   logic             err_clr;
   logic [ERR_W-1:0] err_cnt;
`endif

   gray_stream_decoder #(.WIDTH(W), .ERR_W(ERR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .gray_vld (gray_vld),
      .gray_in  (gray_in),
      .gray_rdy (gray_rdy),
      .bin_rdy  (bin_rdy),
`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
      .err_clr  (err_clr),
      .err_cnt  (err_cnt),
`endif
      .bin_vld  (bin_vld),
      .bin_out  (bin_out),
      .step_up  (step_up),
      .step_err (step_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Reference model state.
   bit      m_have;
   int      m_prev;
   bit      m_vld;
   int      m_bin;
   bit      m_up;
   bit      m_err;
   int      m_cnt;
   bit      clr_req;

   // Gray -> binary as the running XOR of all right shifts.
   function automatic int g2b(input int g);
      int b = 0;
      for (int s = 0; s < int'(W); s++) b ^= (g >> s);
      return b & (MOD - 1);
   endfunction

   function automatic int b2g(input int b);
      return (b ^ (b >> 1)) & (MOD - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".bin_vld"}, 32'(bin_vld), 32'(m_vld));
      if (m_vld) begin
         chk({tag, ".bin_out"},  32'(bin_out),  32'(m_bin));
         chk({tag, ".step_up"},  32'(step_up),  32'(m_up));
         chk({tag, ".step_err"}, 32'(step_err), 32'(m_err));
      end
`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
      chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; gray_vld = 1'b0; gray_in = '0; bin_rdy = 1'b1; clr_req = 1'b0;
`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
      err_clr = 1'b0;
`endif
      @(posedge clk);
      #1;
      m_have = 0; m_prev = 0; m_vld = 0; m_bin = 0; m_up = 0; m_err = 0; m_cnt = 0;
      chk("rst.bin_vld",  32'(bin_vld),  32'd0);
      chk("rst.bin_out",  32'(bin_out),  32'd0);
      chk("rst.step_up",  32'(step_up),  32'd0);
      chk("rst.step_err", 32'(step_err), 32'd0);
      chk("rst.gray_rdy", 32'(gray_rdy), 32'd1);
`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
      chk("rst.err_cnt",  32'(err_cnt),  32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: drive at the falling edge, check ready, then check the
   // outputs just after the rising edge.
   task automatic step(input string tag, input bit v, input int g, input bit r);
      bit acc;
      bit exp_rdy;
      int n;
      int d;
      @(negedge clk);
      gray_vld = v; gray_in = W'(g); bin_rdy = r;
`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
      err_clr = clr_req;
`endif
      #1;
      exp_rdy = !m_vld || r;
      chk({tag, ".gray_rdy"}, 32'(gray_rdy), 32'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clk);
      if (acc) begin
         n = g2b(g);
         if (!m_have) begin
            m_up = 0; m_err = 0; m_have = 1;
         end else begin
            d = (n - m_prev + MOD) % MOD;
            m_up  = (d == 1);
            m_err = !(d == 1 || d == MOD - 1);
         end
         m_prev = n; m_vld = 1; m_bin = n;
      end else if (r) begin
         m_vld = 0;
      end
      if (clr_req) m_cnt = 0;
      else if (acc && m_err && m_cnt < (1 << ERR_W) - 1) m_cnt++;
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int g;
      int mode;
      rst = 1'b1; gray_vld = 1'b0; gray_in = '0; bin_rdy = 1'b1; clr_req = 1'b0;
`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
      err_clr = 1'b0;
`endif

      // First sample is a reference, second is an up step.
      do_reset();
      step("first", 1, 4, 1);
      chk("first.bin7", 32'(bin_out), 32'd7);
      step("up8", 1, 12, 1);
      chk("up8.flag", 32'(step_up), 32'd1);

      // Down step, repeat, then a jump.
      step("down7", 1, 4, 1);
      chk("down7.err", 32'(step_err), 32'd0);
      step("repeat", 1, 4, 1);
      chk("repeat.err", 32'(step_err), 32'd1);
      step("jump5", 1, 7, 1);
      chk("jump5.err", 32'(step_err), 32'd1);
      step("idle", 0, 0, 1);

      // Full up sweep with wrap: 33 samples back to back.
      do_reset();
      for (int i = 0; i <= int'(MOD); i++) step("sweep", 1, b2g(i % int'(MOD)), 1);
      chk("sweep.wrap_up", 32'(step_up), 32'd1);
      // Wrap downwards: 0 -> 31.
      step("wrapdn", 1, b2g(int'(MOD) - 1), 1);
      chk("wrapdn.err", 32'(step_err), 32'd0);

      // Backpressure with a held input.
      step("bp.acc", 1, b2g(5), 1);
      for (int i = 0; i < 3; i++) step("bp.hold", 1, b2g(6), 0);
      chk("bp.stable", 32'(bin_out), 32'd5);
      step("bp.rel", 1, b2g(6), 1);
      chk("bp.next", 32'(bin_out), 32'd6);
      step("bp.drain", 0, 0, 1);

      // Reset while an output is held in TRACK.
      step("mid.a", 1, b2g(10), 1);
      step("mid.b", 1, b2g(11), 0);
      do_reset();
      step("mid.after", 1, 20, 1);
      chk("mid.bin24", 32'(bin_out), 32'd24);
      chk("mid.noerr", 32'(step_err), 32'd0);

`ifdef GRAY_STREAM_DECODER_ERR_CNT_EN
      // Saturation, then a clear that coincides with an error.
      for (int i = 0; i < 5; i++) step("sat", 1, b2g((i * 7 + 3) % int'(MOD)), 1);
      chk("sat.max", 32'(err_cnt), 32'((1 << ERR_W) - 1));
      clr_req = 1'b1;
      step("clr", 1, b2g(17), 1);
      clr_req = 1'b0;
      chk("clr.zero", 32'(err_cnt), 32'd0);
`endif

      // Random traffic: mostly legal steps, some jumps, random stalls.
      do_reset();
      g = 0;
      for (int i = 0; i < 400; i++) begin
         mode = int'($urandom_range(0, 9));
         if (mode < 4)      g = b2g((g2b(g) + 1) % int'(MOD));
         else if (mode < 7) g = b2g((g2b(g) + int'(MOD) - 1) % int'(MOD));
         else               g = int'($urandom_range(0, int'(MOD) - 1));
         clr_req = ($urandom_range(0, 19) == 0);
         step("rand", ($urandom_range(0, 3) != 0), g, ($urandom_range(0, 9) < 7));
      end
      clr_req = 1'b0;

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
